// File: rtl/sram_burst_arbiter_if.sv
// sram_burst_arbiter_if: one burst client's beat handshake and read-return bundle
interface sram_burst_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic req;
  logic we;
  logic last;
  logic gnt;
  logic rvalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, wdata, last, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, last, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_burst_arbiter.sv
// sram_burst_arbiter: round-robin burst arbiter sharing one single-port SRAM between two clients
module sram_burst_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_burst_arbiter_if.slave c0,
  sram_burst_arbiter_if.slave c1,
  output logic                en,
  output logic                wen,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   d,
  input  logic [DATA_W-1:0]   q,
  output logic                burst_err
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nx;
  logic rr_ptr, sel, gnt, sel_last, last_beat, force_end, tag_v, tag_c;
  logic [CW-1:0] beat_cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] d_q;
  // grants are gated by rst_n so the port goes quiet the moment reset asserts
  always_comb begin
    c0.gnt    = rst_n && c0.req && (state == OWN0 || (state == IDLE && (!c1.req || !rr_ptr)));
    c1.gnt    = rst_n && c1.req && (state == OWN1 || (state == IDLE && (!c0.req || rr_ptr)));
    sel       = c1.gnt;
    gnt       = c0.gnt || c1.gnt;
    cnt_nx    = (state == IDLE ? '0 : beat_cnt) + CW'(1);
    force_end = cnt_nx == CW'(MAX_BURST);
    sel_last  = sel ? c1.last : c0.last;
    last_beat = sel_last || force_end;
    state_nx  = !gnt ? state : last_beat ? IDLE : sel ? OWN1 : OWN0;
    en        = gnt;
    wen       = !(gnt && (sel ? c1.we : c0.we));
    addr      = gnt ? (sel ? c1.addr : c0.addr) : addr_q;
    d         = gnt ? (sel ? c1.wdata : c0.wdata) : d_q;
    c0.rvalid = tag_v && !tag_c;
    c1.rvalid = tag_v && tag_c;
    c0.rdata  = c0.rvalid ? q : '0;
    c1.rdata  = c1.rvalid ? q : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
      tag_v     <= 1'b0;
      tag_c     <= 1'b0;
      addr_q    <= '0;
      d_q       <= '0;
    end else begin
      state <= state_nx;
      tag_v <= gnt && wen;
      tag_c <= sel;
      if (gnt) begin
        beat_cnt <= last_beat ? '0 : cnt_nx;
        addr_q   <= addr;
        d_q      <= d;
        if (state == IDLE) rr_ptr <= !sel;
        if (force_end && !sel_last) burst_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sram_burst_arbiter.sv
// tb_sram_burst_arbiter: directed self-checking bench for the two-client SRAM burst arbiter
module tb_sram_burst_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sram_burst_arbiter_if c0();
  sram_burst_arbiter_if c1();
  logic en, wen, burst_err;
  logic [15:0] addr;
  logic [7:0] d;
  logic [7:0] q = 8'h00;
  sram_burst_arbiter dut (
    .clk(clk), .rst_n(rst_n), .c0(c0), .c1(c1), .en(en), .wen(wen),
    .addr(addr), .d(d), .q(q), .burst_err(burst_err)
  );
  logic [7:0] wmem [int];
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  always @(posedge clk)
    if (en) begin
      if (!wen) wmem[int'(addr)] = d;
      else q <= wmem.exists(int'(addr)) ? wmem[int'(addr)] : init_val(addr);
    end
  int n_run = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle_clients();
    c0.req = 0; c0.we = 0; c0.addr = '0; c0.wdata = '0; c0.last = 0;
    c1.req = 0; c1.we = 0; c1.addr = '0; c1.wdata = '0; c1.last = 0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    idle_clients();
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic run(input string nm, input int cyc,
                     input int len0, input int cut0, input int st0, input logic [15:0] b0,
                     input int len1, input int cut1, input int st1, input logic [15:0] b1,
                     input bit nolast0, input int g0a, input int g0b, input int g0c, input int g0d,
                     input int g1a, input int g1b, input int err_at);
    int n0 = 0, n1 = 0, e0 = 0, e1 = 0;
    bit x0 = 0, x1 = 0, eg0, eg1;
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk); #1;
      c0.req = c >= st0 && n0 < len0; c0.we = 0; c0.addr = b0 + 16'(n0);
      c0.last = !nolast0 && (n0 == cut0 - 1 || n0 == len0 - 1);
      c1.req = c >= st1 && n1 < len1; c1.we = 0; c1.addr = b1 + 16'(n1);
      c1.last = n1 == cut1 - 1 || n1 == len1 - 1;
      @(negedge clk);
      eg0 = (c >= g0a && c < g0b) || (c >= g0c && c < g0d);
      eg1 = c >= g1a && c < g1b;
      chk({nm, " gnt0"}, 32'(c0.gnt), 32'(eg0));
      chk({nm, " gnt1"}, 32'(c1.gnt), 32'(eg1));
      chk({nm, " en"}, 32'(en), 32'(eg0 | eg1));
      chk({nm, " wen"}, 32'(wen), 32'(1));
      chk({nm, " rvalid0"}, 32'(c0.rvalid), 32'(x0));
      chk({nm, " rvalid1"}, 32'(c1.rvalid), 32'(x1));
      chk({nm, " burst_err"}, 32'(burst_err), 32'(c >= err_at));
      if (x0) chk({nm, " rdata0"}, 32'(c0.rdata), 32'(init_val(b0 + 16'(e0 - 1))));
      if (x1) chk({nm, " rdata1"}, 32'(c1.rdata), 32'(init_val(b1 + 16'(e1 - 1))));
      if (eg0) e0++;
      if (eg1) e1++;
      x0 = eg0;
      x1 = eg1;
      if (c0.gnt) n0++;
      if (c1.gnt) n1++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    idle_clients();
    @(negedge clk);
    chk("rst gnt0", 32'(c0.gnt), 32'(0));
    chk("rst gnt1", 32'(c1.gnt), 32'(0));
    chk("rst en", 32'(en), 32'(0));
    chk("rst wen", 32'(wen), 32'(1));
    chk("rst addr", 32'(addr), 32'(0));
    chk("rst d", 32'(d), 32'(0));
    chk("rst rvalid", 32'({c0.rvalid, c1.rvalid}), 32'(0));
    chk("rst burst_err", 32'(burst_err), 32'(0));
    @(posedge clk); #1;
    rst_n = 1;
    run("t1", 6, 4, 4, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 4, 0, 0, 0, 0, 1000);
    do_reset();
    run("t2", 34, 16, 16, 0, 16'h0100, 16, 16, 0, 16'h0200, 0, 0, 16, 0, 0, 16, 32, 1000);
    do_reset();
    run("t3", 21, 18, 16, 0, 16'h0300, 1, 1, 2, 16'h0400, 0, 0, 16, 17, 19, 16, 17, 1000);
    @(posedge clk); #1;
    idle_clients();
    c1.req = 1; c1.we = 1; c1.addr = 16'h1000; c1.wdata = 8'hA5; c1.last = 1;
    @(negedge clk);
    chk("t4 gnt1", 32'(c1.gnt), 32'(1));
    chk("t4 gnt0", 32'(c0.gnt), 32'(0));
    chk("t4 en", 32'(en), 32'(1));
    chk("t4 wen", 32'(wen), 32'(0));
    chk("t4 addr", 32'(addr), 32'h1000);
    chk("t4 d", 32'(d), 32'hA5);
    @(posedge clk); #1;
    idle_clients();
    c0.req = 1; c0.addr = 16'h1000; c0.last = 1;
    @(negedge clk);
    chk("t4 no rvalid1", 32'(c1.rvalid), 32'(0));
    chk("t4 rd gnt0", 32'(c0.gnt), 32'(1));
    chk("t4 rd wen", 32'(wen), 32'(1));
    @(posedge clk); #1;
    idle_clients();
    @(negedge clk);
    chk("t4 rvalid0", 32'(c0.rvalid), 32'(1));
    chk("t4 rdata0", 32'(c0.rdata), 32'hA5);
    chk("t4 idle en", 32'(en), 32'(0));
    chk("t4 addr hold", 32'(addr), 32'h1000);
    chk("t4 rvalid1", 32'(c1.rvalid), 32'(0));
    do_reset();
    run("t5", 18, 16, 16, 0, 16'h0500, 1, 1, 0, 16'h0600, 1, 0, 16, 0, 0, 16, 17, 16);
    run("t5b", 3, 1, 1, 0, 16'h0700, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    c0.req = 1; c0.we = 0; c0.addr = 16'h0800; c0.last = 0;
    @(negedge clk);
    chk("t6 beat1 gnt0", 32'(c0.gnt), 32'(1));
    @(posedge clk); #1;
    c0.addr = 16'h0801;
    #1 rst_n = 0;
    @(negedge clk);
    chk("t6 rst gnt0", 32'(c0.gnt), 32'(0));
    chk("t6 rst en", 32'(en), 32'(0));
    chk("t6 rst wen", 32'(wen), 32'(1));
    chk("t6 rst rvalid0", 32'(c0.rvalid), 32'(0));
    chk("t6 rst addr", 32'(addr), 32'(0));
    chk("t6 rst burst_err", 32'(burst_err), 32'(0));
    @(posedge clk); #1;
    rst_n = 1;
    c0.addr = 16'h0900; c0.last = 1;
    c1.req = 1; c1.we = 0; c1.addr = 16'h0A00; c1.last = 1;
    @(negedge clk);
    chk("t6 post gnt0", 32'(c0.gnt), 32'(1));
    chk("t6 post gnt1", 32'(c1.gnt), 32'(0));
    @(posedge clk); #1;
    c0.req = 0;
    @(negedge clk);
    chk("t6 rvalid0", 32'(c0.rvalid), 32'(1));
    chk("t6 rdata0", 32'(c0.rdata), 32'(init_val(16'h0900)));
    chk("t6 next gnt1", 32'(c1.gnt), 32'(1));
    @(posedge clk); #1;
    idle_clients();
    @(negedge clk);
    chk("t6 rvalid1", 32'(c1.rvalid), 32'(1));
    chk("t6 rdata1", 32'(c1.rdata), 32'(init_val(16'h0A00)));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
